// File: rtl/contador_pkg.sv
// Shared constants for the parametrised counter: MODO encodings and default sizing.
package contador_pkg;

  localparam logic [1:0] MODO_UP   = 2'b00;
  localparam logic [1:0] MODO_DOWN = 2'b01;
  localparam logic [1:0] MODO_STEP = 2'b10;
  localparam logic [1:0] MODO_LOAD = 2'b11;

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefStep  = 3;

endpackage

// File: rtl/contador_next.sv
// Next-state logic for contador_param: count/load/wrap decisions and the RCO pulse.
// Saturating variant selected with `define CONTADOR_SAT_EN.
module contador_next
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned STEP  = DefStep
) (
  input  logic [WIDTH-1:0] q,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] lim,
  input  logic             enb,
  input  logic             ci,
  output logic [WIDTH-1:0] next_q,
  output logic             next_rco
);

  localparam logic [WIDTH-1:0] StepW = WIDTH'(STEP);

  // LIM+1 needs the extra bit so LIM = all-ones still compares correctly against STEP.
  logic [WIDTH:0] lim_p1;
  assign lim_p1 = {1'b0, lim} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    next_q   = q;
    next_rco = 1'b0;
    if (enb) begin
      if (modo == MODO_LOAD) begin
        next_q = d;
      end else if (ci) begin
        case (modo)
          MODO_UP: begin
            if (q >= lim) begin
              next_rco = 1'b1;
`ifdef CONTADOR_SAT_EN
              next_q = lim;
`else
              next_q = '0;
`endif
            end else begin
              next_q = q + 1'b1;
            end
          end
          MODO_DOWN: begin
            if (q > lim) begin
              next_q   = lim;
              next_rco = 1'b1;
            end else if (q == '0) begin
              next_rco = 1'b1;
`ifdef CONTADOR_SAT_EN
              next_q = '0;
`else
              next_q = lim;
`endif
            end else begin
              next_q = q - 1'b1;
            end
          end
          MODO_STEP: begin
            if (q > lim) begin
              next_q   = lim;
              next_rco = 1'b1;
            end else if (q >= StepW) begin
              next_q = q - StepW;
            end else begin
              next_rco = 1'b1;
`ifdef CONTADOR_SAT_EN
              next_q = '0;
`else
              // Borrow the shortfall from LIM+1; result stays within 0..LIM so WIDTH bits suffice.
              if (lim_p1 >= {1'b0, StepW}) begin
                next_q = lim - (StepW - q - 1'b1);
              end else begin
                next_q = lim;
              end
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/contador_param.sv
// WIDTH-bit up/down/step/load counter with runtime LIM and cascadable CI/RCO.
// Define CONTADOR_SAT_EN for saturating rather than wrapping behaviour.
module contador_param
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned STEP  = DefStep
) (
  input  logic             CLK,
  input  logic             RST_L,
  input  logic             ENB,
  input  logic             CI,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] LIM,
  output logic [WIDTH-1:0] Q,
  output logic             RCO
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             rco_q, rco_d;

  contador_next #(
    .WIDTH(WIDTH),
    .STEP (STEP)
  ) u_next (
    .q       (cnt_q),
    .modo    (MODO),
    .d       (D),
    .lim     (LIM),
    .enb     (ENB),
    .ci      (CI),
    .next_q  (cnt_d),
    .next_rco(rco_d)
  );

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      cnt_q <= '0;
      rco_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rco_q <= rco_d;
    end
  end

  assign Q   = cnt_q;
  assign RCO = rco_q;

endmodule

// File: tb/tb_contador_param.sv
// Scoreboard bench for contador_param (WIDTH=4, STEP=3); honours CONTADOR_SAT_EN.
module tb_contador_param;

  logic       CLK = 1'b0;
  logic       RST_L = 1'b0;
  logic       ENB = 1'b0;
  logic       CI = 1'b0;
  logic [1:0] MODO = 2'b00;
  logic [3:0] D = 4'd0;
  logic [3:0] LIM = 4'd15;
  logic [3:0] Q;
  logic       RCO;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] q;
    logic       rco;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  contador_param #(
    .WIDTH(4),
    .STEP (3)
  ) dut (
    .CLK  (CLK),
    .RST_L(RST_L),
    .ENB  (ENB),
    .CI   (CI),
    .MODO (MODO),
    .D    (D),
    .LIM  (LIM),
    .Q    (Q),
    .RCO  (RCO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [3:0] aq, input logic ar,
                       input logic [3:0] eq, input logic er);
    n_cmp++;
    if (aq !== eq || ar !== er) begin
      n_err++;
      $display("FAIL %s: got Q=%0d RCO=%0b, expected Q=%0d RCO=%0b", name, aq, ar, eq, er);
    end
  endtask

  // Apply inputs mid-cycle and queue the registered result expected after the next rising edge.
  task automatic drive(input logic enb, input logic ci, input logic [1:0] modo,
                       input logic [3:0] d, input logic [3:0] lim,
                       input logic [3:0] eq, input logic er, input string name);
    @(negedge CLK);
    ENB  = enb;
    CI   = ci;
    MODO = modo;
    D    = d;
    LIM  = lim;
    exp_q.push_back('{q: eq, rco: er, name: name});
  endtask

  always @(posedge CLK) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check(mon_e.name, Q, RCO, mon_e.q, mon_e.rco);
    end
  end

  initial begin
    logic [3:0] seq_q[12];
    logic       seq_r[12];

    #2;
    check("reset_state", Q, RCO, 4'd0, 1'b0);
    @(negedge CLK);
    RST_L = 1'b1;

    // Count to 6, then async reset between edges.
    for (int i = 1; i <= 6; i++) drive(1, 1, 2'b00, 4'd0, 4'd15, 4'(i), 1'b0, "up_to6");
    @(negedge CLK);
    RST_L = 1'b0;
    #1;
    check("async_rst", Q, RCO, 4'd0, 1'b0);
    #1;
    RST_L = 1'b1;
    exp_q.push_back('{q: 4'd1, rco: 1'b0, name: "post_rst"});

    drive(1, 1, 2'b11, 4'd0, 4'd9, 4'd0, 1'b0, "load0");
`ifndef CONTADOR_SAT_EN
    // LIM=9 wrap sequence.
    seq_q = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    seq_r = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 12; i++) drive(1, 1, 2'b00, 4'd0, 4'd9, seq_q[i], seq_r[i], "up_lim9");

    // Step-by-3 wrap through LIM+1.
    drive(1, 1, 2'b11, 4'd4, 4'd15, 4'd4, 1'b0, "load4");
    drive(1, 1, 2'b10, 4'd0, 4'd15, 4'd1, 1'b0, "step_a");
    drive(1, 1, 2'b10, 4'd0, 4'd15, 4'd14, 1'b1, "step_wrap");
    drive(1, 1, 2'b10, 4'd0, 4'd15, 4'd11, 1'b0, "step_b");
    drive(1, 1, 2'b10, 4'd0, 4'd15, 4'd8, 1'b0, "step_c");

    // LIM+1 < STEP falls back to LIM, repeatedly.
    drive(1, 1, 2'b11, 4'd0, 4'd1, 4'd0, 1'b0, "load0_lim1");
    drive(1, 1, 2'b10, 4'd0, 4'd1, 4'd1, 1'b1, "step_small_lim");
    drive(1, 1, 2'b10, 4'd0, 4'd1, 4'd1, 1'b1, "step_small_lim2");

    // Full-range binary wrap in both directions.
    drive(1, 1, 2'b11, 4'd0, 4'd15, 4'd0, 1'b0, "load0_full");
    drive(1, 1, 2'b01, 4'd0, 4'd15, 4'd15, 1'b1, "down_wrap");
    drive(1, 1, 2'b00, 4'd0, 4'd15, 4'd0, 1'b1, "up_wrap");
`else
    drive(1, 1, 2'b11, 4'd14, 4'd15, 4'd14, 1'b0, "sat_load14");
    drive(1, 1, 2'b00, 4'd0, 4'd15, 4'd15, 1'b0, "sat_up_a");
    drive(1, 1, 2'b00, 4'd0, 4'd15, 4'd15, 1'b1, "sat_up_b");
    drive(1, 1, 2'b00, 4'd0, 4'd15, 4'd15, 1'b1, "sat_up_c");
    drive(1, 1, 2'b11, 4'd1, 4'd15, 4'd1, 1'b0, "sat_load1");
    drive(1, 1, 2'b10, 4'd0, 4'd15, 4'd0, 1'b1, "sat_step_floor");
    drive(1, 1, 2'b01, 4'd0, 4'd15, 4'd0, 1'b1, "sat_down_floor");
`endif

    // Load above LIM, then down clamps to LIM.
    drive(1, 1, 2'b11, 4'd12, 4'd9, 4'd12, 1'b0, "load12");
    drive(1, 1, 2'b01, 4'd0, 4'd9, 4'd9, 1'b1, "down_clamp");
    drive(1, 1, 2'b01, 4'd0, 4'd9, 4'd8, 1'b0, "down_after");

    // Hold conditions and load ignoring CI.
    drive(1, 0, 2'b00, 4'd0, 4'd9, 4'd8, 1'b0, "ci0_hold");
    drive(1, 0, 2'b11, 4'd7, 4'd9, 4'd7, 1'b0, "load_ci0");
    drive(0, 1, 2'b00, 4'd3, 4'd9, 4'd7, 1'b0, "enb0_up");
    drive(0, 1, 2'b11, 4'd2, 4'd9, 4'd7, 1'b0, "enb0_load");
    drive(0, 1, 2'b10, 4'd2, 4'd9, 4'd7, 1'b0, "enb0_step");

    repeat (3) @(posedge CLK);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/contador_param.md
Name: contador_param

Overview:
- Parametrised successor of the 4-bit mode counter: WIDTH-bit up/down/step/load counter with a runtime modulo limit (LIM) and a carry-in (CI) for cascading.
- Registered, one-cycle wrap flag RCO.
- Asynchronous active-low reset.
- Replaces hand-cascaded fixed-width stages: N instances chain RCO->CI, or one instance is set to the full width.

Parameters:
- WIDTH, 4, counter/data width in bits (>=2).
- STEP, 3, decrement used in MODO=2'b10 (1 <= STEP <= 2**WIDTH-1).

Ports:
- CLK  input  1  rising-edge clock
- RST_L  input  1  asynchronous active-low reset
- ENB  input  1  global enable; 0 = hold
- CI  input  1  carry-in; counting modes advance only when ENB&CI
- MODO  input  2  00 up by 1, 01 down by 1, 10 down by STEP, 11 load D
- D  input  WIDTH  load value
- LIM  input  WIDTH  terminal value; count range is 0..LIM
- Q  output  WIDTH  count, registered
- RCO  output  1  registered wrap pulse

Behaviour:
- Reset: RST_L=0 forces Q=0 and RCO=0 immediately, without waiting for a clock edge. This overrides any operation in progress. The first update after release occurs on the first CLK rise with RST_L=1.
- All updates happen on the CLK rising edge. Q and RCO are registered, so there is one cycle of latency from inputs to outputs.
- ENB=0: Q holds, RCO=0.
- MODO=11 with ENB=1: Q<=D regardless of CI and LIM; RCO=0. D>LIM is legal.
- Counting modes with ENB=1, CI=0: Q holds, RCO=0.
- Counting modes with ENB=1, CI=1 (RCO=0 unless stated):
  - 00: Q>=LIM -> Q<=0, RCO=1; else Q<=Q+1.
  - 01: Q>LIM -> Q<=LIM, RCO=1; Q==0 -> Q<=LIM, RCO=1; else Q<=Q-1.
  - 10: Q>LIM -> Q<=LIM, RCO=1; Q>=STEP -> Q<=Q-STEP; Q<STEP with LIM+1>=STEP -> Q<=LIM+1-(STEP-Q), RCO=1; Q<STEP with LIM+1<STEP -> Q<=LIM, RCO=1.
- Arithmetic is done at WIDTH+1 bits internally. LIM=2**WIDTH-1 gives plain binary wrap.
- RCO is high for exactly the one cycle in which Q holds the wrapped value. Repeated wraps give repeated pulses.
- LIM changing mid-count takes effect on the next edge, using the rules above.
- Cascade: low stage RCO feeds the next stage's CI. The upper stage advances one edge after the lower wraps; this one-cycle skew per stage is by design.

Optional Feature:
- Macro: CONTADOR_SAT_EN.
- Defined: saturating instead of wrapping.
  - Mode 00 at Q>=LIM: Q<=LIM, RCO=1.
  - Modes 01/10 that would cross below 0: Q<=0, RCO=1.
  - Q>LIM in down modes still clamps to LIM with RCO=1.
  - RCO stays high every cycle a count is attempted at the boundary.
- Undefined: wrap behaviour as above.
- Load behaviour is identical in both cases.

Decomposition:
- Package contador_pkg:
  - MODO_UP=2'b00, MODO_DOWN=2'b01, MODO_STEP=2'b10, MODO_LOAD=2'b11.
  - Default WIDTH/STEP constants.
- Sub-module contador_next: purely combinational.
  - Inputs: Q, MODO, D, LIM, ENB, CI.
  - Outputs: next_q, next_rco.
- The top level holds only the two async-reset registers.

Test Plan (WIDTH=4, STEP=3):
- Count to 6 in mode 00 (LIM=15), then pull RST_L low between edges -> Q=0 and RCO=0 before the next edge; first post-release edge gives Q=1.
- Mode 00, LIM=9, ENB=CI=1, 12 edges from Q=0 -> sequence 1..9,0,1,2; RCO=1 only in the cycle Q=0 after 9.
- Load D=4 (LIM=15), then mode 10 -> Q sequence 1, 14 (RCO=1), 11, 8; RCO=0 on the others.
- Load D=12 with LIM=9, then mode 01 -> Q=9 with RCO=1, then 8.
- ENB=1, CI=0 in mode 00 -> Q holds and RCO=0; MODO=11, D=7, CI=0 -> Q=7. ENB=0 with any MODO -> Q holds.
- CONTADOR_SAT_EN build, LIM=15, Q=14, mode 00 for 3 edges -> Q=15,15,15 with RCO=0,1,1. Then mode 10 from Q=1 -> Q=0, RCO=1.
